register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter ROBWD, default `ROBWD from Def.v, meaning the width of the ROB index.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-005 SHALL have port jump_wrong_flag  input  1  mispredict flush from the ROB.
REQ-006 SHALL have ports ID_inst_flag / ID_inst_rd / ID_rob_id  input  1/5/32  rename request: rd gets tag ID_rob_id.
REQ-007 SHALL have ports ID_rs1 / ID_rs2  input  5/5  operand register indices.
REQ-008 SHALL have ports RF_rs1_busy / RF_rs2_busy  output  1/1  operand still pending in the ROB.
REQ-009 SHALL have ports RF_rs1_val / RF_rs2_val  output  32/32  operand value, valid when busy=0.
REQ-010 SHALL have ports RF_rs1_tag / RF_rs2_tag  output  32/32  producing ROB id, valid when busy=1.
REQ-011 SHALL have ports RF_id1_cut / RF_id2_cut  output  ROBWD/ROBWD  ROB index queried for rs1/rs2.
REQ-012 SHALL have ports RF_id1_ready / RF_id2_ready / RF_id1_val / RF_id2_val  input  1/1/32/32  ROB entry ready and value.
REQ-013 SHALL have ports ROB_cmt_rf_flag / ROB_cmt_rf_rd / ROB_cmt_rf_rob_id / ROB_cmt_rf_val  input  1/5/32/32  commit write.
REQ-014 SHALL have port rf_stall  output  1  same-cycle commit/read conflict; decode must retry.

Function
REQ-015 SHALL hold 32x32-bit values, 32 tag-valid bits and 32x32-bit tags; x0 is never written, never tagged, and always reads 0 with busy=0.
REQ-016 SHALL drive RF_idN_cut = tag[rsN][ROBWD-1:0] combinationally.
REQ-017 SHALL resolve each operand combinationally in this priority: x0 -> 0; tag invalid -> regs[rsN]; commit bypass (REQ-026) -> ROB_cmt_rf_val; RF_idN_ready -> RF_idN_val; otherwise busy=1 with tag[rsN].
REQ-018 SHALL, on commit (flag=1, rd!=0), write regs[rd] <= val, and clear tag-valid[rd] only if tag[rd]==ROB_cmt_rf_rob_id.
REQ-019 SHALL, on rename (ID_inst_flag=1, rd!=0), set tag-valid[rd]=1 and tag[rd]=ID_rob_id.
REQ-020 SHALL let rename win over a commit tag-clear on the same rd in the same cycle; the value write still occurs.
REQ-021 SHALL resolve operand reads against pre-edge state, so a same-cycle rename of rsN=rd does not affect that read.
REQ-022 SHALL, on jump_wrong_flag=1, clear all tag-valid bits, ignore any rename, and still perform a simultaneous commit value write.
REQ-023 SHALL, while rdy=0, update no state; combinational outputs stay live.

Reset
REQ-024 SHALL, on rst=0 and asynchronously, zero all 32 registers, clear all tag-valid bits, and clear all tags.
REQ-025 SHALL, out of reset, drive RF_rsN_busy=0, RF_rsN_val=0 and rf_stall=0; a reset mid-rename discards the rename.

Configuration
REQ-026 SHALL, with RF_BYPASS_EN defined, treat rsN as ready whenever commit flag=1, rd==rsN!=0, tag-valid[rsN]=1 and tag[rsN]==ROB_cmt_rf_rob_id, and SHALL tie rf_stall to 0.
REQ-027 SHALL, without RF_BYPASS_EN, omit the bypass and assert rf_stall combinationally under that same condition for rs1 or rs2; in that case the operand outputs are don't-care.

Verification
REQ-028 SHALL cover reset release: rs1=5 -> busy=0, val=0; write x0 with 0xFF via commit -> x0 still reads 0.
REQ-029 SHALL cover rename then commit: rename x3 to tag 7, then rs1=3 -> busy=1, tag=7, cut=7; commit rd=3, id=7, val=0x1234 -> next cycle busy=0, val=0x1234.
REQ-030 SHALL cover a stale commit: x3 renamed 7 then 9; commit id 7 val 0xAA -> regs[3]=0xAA, busy=1, tag=9; RF_id1_ready=1, RF_id1_val=0xBB -> val=0xBB, busy=0.
REQ-031 SHALL cover same-cycle commit and read: tag[4]=2, commit rd=4, id=2, val=0x55, rs2=4 -> with RF_BYPASS_EN val=0x55, busy=0, rf_stall=0; without it rf_stall=1.
REQ-032 SHALL cover flush: x1..x31 all tagged, jump_wrong_flag=1 together with commit rd=6, val=0x77 and a rename of x8 -> next cycle no register busy, regs[6]=0x77, x8 untagged.
REQ-033 SHALL cover rdy and asynchronous reset: rdy=0 during a commit -> no change; rst=0 asserted between clock edges -> state clears immediately.

Source files
------------

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 32 x 32-bit architectural register file with rename tags for
//               an out-of-order core. Each register carries a valid bit and
//               the ROB id of its newest pending producer. Operand reads
//               resolve through the ROB entry lookup (RF_idN_*). Commit
//               writes retire values. A mispredict flush drops every tag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   rdy                   global enable, low freezes all state
//   jump_wrong_flag       flush: clear all tags, suppress rename
//   ID_inst_flag/rd/rob_id rename request (rd gets tag rob_id)
//   ID_rs1/ID_rs2         operand register indices
//   RF_rsN_busy/val/tag   resolved operand (val if !busy, tag if busy)
//   RF_idN_cut            ROB index looked up for operand N
//   RF_idN_ready/val      ROB entry readiness and value for that index
//   ROB_cmt_rf_*          commit write port
//   rf_stall              commit/read conflict, decode must retry
// Configuration
//   RF_BYPASS_EN          when defined, a same-cycle matching commit is
//                         forwarded to the read; otherwise rf_stall is raised
// ============================================================================

`ifndef ROBWD
`define ROBWD 4
`endif

module register_file #(
    parameter int ROBWD = `ROBWD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             jump_wrong_flag,
    input  logic             ID_inst_flag,
    input  logic [4:0]       ID_inst_rd,
    input  logic [31:0]      ID_rob_id,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    output logic             RF_rs1_busy,
    output logic             RF_rs2_busy,
    output logic [31:0]      RF_rs1_val,
    output logic [31:0]      RF_rs2_val,
    output logic [31:0]      RF_rs1_tag,
    output logic [31:0]      RF_rs2_tag,
    output logic [ROBWD-1:0] RF_id1_cut,
    output logic [ROBWD-1:0] RF_id2_cut,
    input  logic             RF_id1_ready,
    input  logic             RF_id2_ready,
    input  logic [31:0]      RF_id1_val,
    input  logic [31:0]      RF_id2_val,
    input  logic             ROB_cmt_rf_flag,
    input  logic [4:0]       ROB_cmt_rf_rd,
    input  logic [31:0]      ROB_cmt_rf_rob_id,
    input  logic [31:0]      ROB_cmt_rf_val,
    output logic             rf_stall
);

    typedef struct packed {
        logic        busy;
        logic [31:0] val;
        logic [31:0] tag;
    } operand_t;

    logic [31:0] regs [32];
    logic [31:0] tags [32];
    logic [31:0] tag_valid;

    logic     hit1;
    logic     hit2;
    operand_t op1;
    operand_t op2;

`ifdef RF_BYPASS_EN
    localparam logic BYPASS = 1'b1;
    assign rf_stall = 1'b0;
`else
    localparam logic BYPASS = 1'b0;
    assign rf_stall = hit1 | hit2;
`endif

    // A commit retiring exactly the producer an operand is waiting on. The
    // ROB entry is being freed this cycle, so its ready/value cannot be
    // trusted; either forward the commit value or stall decode.
    assign hit1 = ROB_cmt_rf_flag && (ROB_cmt_rf_rd != 5'd0) &&
                  (ROB_cmt_rf_rd == ID_rs1) && tag_valid[ID_rs1] &&
                  (tags[ID_rs1] == ROB_cmt_rf_rob_id);
    assign hit2 = ROB_cmt_rf_flag && (ROB_cmt_rf_rd != 5'd0) &&
                  (ROB_cmt_rf_rd == ID_rs2) && tag_valid[ID_rs2] &&
                  (tags[ID_rs2] == ROB_cmt_rf_rob_id);

    function automatic operand_t resolve(
        input logic [4:0]  rs,
        input logic        valid,
        input logic [31:0] value,
        input logic [31:0] tag,
        input logic        bypass_hit,
        input logic        rob_ready,
        input logic [31:0] rob_val
    );
        operand_t o;
        o = '0;
        if (rs == 5'd0) begin
            o = '0;
        end else if (!valid) begin
            o.val = value;
        end else if (bypass_hit) begin
            o.val = ROB_cmt_rf_val;
        end else if (rob_ready) begin
            o.val = rob_val;
        end else begin
            o.busy = 1'b1;
            o.tag  = tag;
        end
        return o;
    endfunction

    always_comb begin
        op1 = resolve(ID_rs1, tag_valid[ID_rs1], regs[ID_rs1], tags[ID_rs1],
                      BYPASS & hit1, RF_id1_ready, RF_id1_val);
        op2 = resolve(ID_rs2, tag_valid[ID_rs2], regs[ID_rs2], tags[ID_rs2],
                      BYPASS & hit2, RF_id2_ready, RF_id2_val);
    end

    assign RF_rs1_busy = op1.busy;
    assign RF_rs1_val  = op1.val;
    assign RF_rs1_tag  = op1.tag;
    assign RF_rs2_busy = op2.busy;
    assign RF_rs2_val  = op2.val;
    assign RF_rs2_tag  = op2.tag;

    assign RF_id1_cut  = tags[ID_rs1][ROBWD-1:0];
    assign RF_id2_cut  = tags[ID_rs2][ROBWD-1:0];

    // Later assignments take precedence: rename overrides the commit tag
    // clear on the same rd, and flush overrides everything tag-related.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
            tag_valid <= '0;
        end else if (rdy) begin
            if (ROB_cmt_rf_flag && (ROB_cmt_rf_rd != 5'd0)) begin
                regs[ROB_cmt_rf_rd] <= ROB_cmt_rf_val;
                if (tags[ROB_cmt_rf_rd] == ROB_cmt_rf_rob_id) begin
                    tag_valid[ROB_cmt_rf_rd] <= 1'b0;
                end
            end
            if (jump_wrong_flag) begin
                tag_valid <= '0;
            end else if (ID_inst_flag && (ID_inst_rd != 5'd0)) begin
                tag_valid[ID_inst_rd] <= 1'b1;
                tags[ID_inst_rd]      <= ID_rob_id;
            end
        end
    end

endmodule

`default_nettype wire
